data_mem_responder: RTL

Memory-side responder for the processor's data port. It serves word loads combinationally and stores on the clock edge, using a local RAM and a small memory-mapped peripheral window: status, a transmit FIFO draining to a valid/ready byte stream, a cycle counter and an LED register. It sits between the core's data interface (address, write strobe, write data, read data) and the board-level output logic.

---
 rtl/data_mem_pkg.sv | 30 +++
 rtl/data_mem_responder_tx_fifo.sv | 42 ++++
 rtl/data_mem_responder.sv | 82 ++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: address map and STATUS layout for data_mem_responder
package data_mem_pkg;

    localparam logic [11:0] ADDR_STATUS = 12'h800;
    localparam logic [11:0] ADDR_TXDATA = 12'h804;
    localparam logic [11:0] ADDR_CYCLE  = 12'h808;
    localparam logic [11:0] ADDR_LED    = 12'h80C;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_OVF     = 8;
    localparam int CNT_W        = 4;

    function automatic logic [31:0] status_word(
        input logic             empty,
        input logic             full,
        input logic [CNT_W-1:0] cnt,
        input logic             ovf
    );
        logic [31:0] s;
        s = '0;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL] = full;
        s[STAT_CNT_LSB +: CNT_W] = cnt;
        s[STAT_OVF] = ovf;
        return s;
    endfunction

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// tx_fifo: circular FIFO with extra-MSB pointers; push while full is accepted only alongside a pop
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_pop, do_push;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count   = wp - rp;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= do_pop ? rp + 1'b1 : rp;
        end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port responder with local RAM, TX FIFO, cycle counter and LED register
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic [15:0] LED
);

    localparam int RW  = $clog2(RAM_WORDS);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] RAM_LIM = 10'(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    logic [9:0]  word;
    logic        hi_zero, ram_sel, hit_status, hit_tx, hit_cycle, hit_led;
    logic        push, pop, full, empty, ovf;
    logic [FAW:0] fifo_cnt;
    logic [31:0] cycle, status;
    logic [15:0] led_reg;
    logic        unused_addr;

    assign unused_addr = ^Addr[1:0];
    assign word        = Addr[11:2];
    assign hi_zero     = Addr[31:12] == '0;
    assign ram_sel     = hi_zero && word < RAM_LIM;
    assign hit_status  = hi_zero && word == ADDR_STATUS[11:2];
    assign hit_tx      = hi_zero && word == ADDR_TXDATA[11:2];
    assign hit_cycle   = hi_zero && word == ADDR_CYCLE[11:2];
    assign hit_led     = hi_zero && word == ADDR_LED[11:2];

    assign push    = MemWrite && hit_tx;
    assign TxValid = !empty;
    assign pop     = TxValid && TxReady;
    assign LED     = led_reg;
    assign status  = status_word(empty, full, CNT_W'(fifo_cnt), ovf);

    tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (CLK),
        .rst_n(Reset),
        .push (push),
        .din  (WriteData[7:0]),
        .pop  (pop),
        .dout (TxData),
        .full (full),
        .empty(empty),
        .count(fifo_cnt)
    );

    always_comb
        ReadData = ram_sel    ? ram[Addr[RW+1:2]] :
                   hit_status ? status :
                   hit_cycle  ? cycle :
                   hit_led    ? {16'b0, led_reg} : '0;

    always_ff @(posedge CLK)
        if (MemWrite && ram_sel) ram[Addr[RW+1:2]] <= WriteData;

    // a push into a full FIFO is only lost when no pop frees a slot that same edge
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) begin
            ovf     <= 1'b0;
            cycle   <= '0;
            led_reg <= '0;
        end else begin
            cycle   <= (MemWrite && hit_cycle) ? '0 : cycle + 32'd1;
            led_reg <= (MemWrite && hit_led) ? WriteData[15:0] : led_reg;
            ovf     <= (MemWrite && hit_status && WriteData[STAT_OVF]) ? 1'b0 :
                       (push && full && !pop) ? 1'b1 : ovf;
        end

endmodule
